// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4 read arbiter.
package axi_arb_pkg;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFU_AR = 3'd1,
    IFU_R  = 3'd2,
    LSU_AR = 3'd3,
    LSU_R  = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_IFU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  localparam logic [ID_W-1:0]   ID_IFU = 4'd0;
  localparam logic [ID_W-1:0]   ID_LSU = 4'd1;
  localparam logic [RESP_W-1:0] OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_rd_beat_chk.sv
// Counts R beats of the granted burst and raises a sticky flag when the
// slave's rlast disagrees with the granted ARLEN.
module axi_rd_beat_chk
  import axi_arb_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             ar_load,
  input  logic [LEN_W-1:0] arlen,
  input  logic             r_beat,
  input  logic             rlast,
  output logic             o_protocol_err
);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             len_hit_c;

  // Current beat is the one ARLEN says must carry rlast.
  assign len_hit_c = (beat_cnt == len_q);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      len_q          <= '0;
      beat_cnt       <= '0;
      o_protocol_err <= 1'b0;
    end else begin
      if (ar_load) begin
        len_q    <= arlen;
        beat_cnt <= '0;
      end else if (r_beat) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      // Early rlast, or missing rlast on the final beat.
      if (r_beat && (rlast != len_hit_c)) begin
        o_protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master (IFU/LSU) AXI4 read arbiter: one outstanding transaction,
// alternating grant on ties, combinational AR/R pass-through per state.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,

  input  logic [ADDR_W-1:0]  i_ifu_araddr,
  input  logic [LEN_W-1:0]   i_ifu_arlen,
  input  logic [SIZE_W-1:0]  i_ifu_arsize,
  input  logic [BURST_W-1:0] i_ifu_arburst,
  input  logic               i_ifu_arvalid,
  output logic               o_ifu_arready,
  output logic [DATA_W-1:0]  o_ifu_rdata,
  output logic [RESP_W-1:0]  o_ifu_rresp,
  output logic               o_ifu_rlast,
  output logic               o_ifu_rvalid,
  input  logic               i_ifu_rready,

  input  logic [ADDR_W-1:0]  i_lsu_araddr,
  input  logic [LEN_W-1:0]   i_lsu_arlen,
  input  logic [SIZE_W-1:0]  i_lsu_arsize,
  input  logic [BURST_W-1:0] i_lsu_arburst,
  input  logic               i_lsu_arvalid,
  output logic               o_lsu_arready,
  output logic [DATA_W-1:0]  o_lsu_rdata,
  output logic [RESP_W-1:0]  o_lsu_rresp,
  output logic               o_lsu_rlast,
  output logic               o_lsu_rvalid,
  input  logic               i_lsu_rready,

  output logic [ADDR_W-1:0]  o_m_araddr,
  output logic [ID_W-1:0]    o_m_arid,
  output logic [LEN_W-1:0]   o_m_arlen,
  output logic [SIZE_W-1:0]  o_m_arsize,
  output logic [BURST_W-1:0] o_m_arburst,
  output logic               o_m_arvalid,
  input  logic               i_m_arready,
  input  logic [DATA_W-1:0]  i_m_rdata,
  input  logic [RESP_W-1:0]  i_m_rresp,
  input  logic [ID_W-1:0]    i_m_rid,
  input  logic               i_m_rlast,
  input  logic               i_m_rvalid,
  output logic               o_m_rready,

  output logic               o_protocol_err
);

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;
  logic   ar_hs_c;
  logic   r_hs_c;

  // R routing follows the FSM state, so the returned ID is not needed.
  logic unused_rid;
  assign unused_rid = ^i_m_rid;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_IFU;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    ar_hs_c       = 1'b0;
    r_hs_c        = 1'b0;
    o_m_arvalid   = 1'b0;
    o_m_araddr    = '0;
    o_m_arid      = '0;
    o_m_arlen     = '0;
    o_m_arsize    = '0;
    o_m_arburst   = '0;
    o_m_rready    = 1'b0;
    o_ifu_arready = 1'b0;
    o_lsu_arready = 1'b0;
    o_ifu_rvalid  = 1'b0;
    o_ifu_rdata   = '0;
    o_ifu_rresp   = '0;
    o_ifu_rlast   = 1'b0;
    o_lsu_rvalid  = 1'b0;
    o_lsu_rdata   = '0;
    o_lsu_rresp   = '0;
    o_lsu_rlast   = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, grant whichever master was not served last.
        if (i_ifu_arvalid && i_lsu_arvalid) begin
          state_d = (last_grant_q == GRANT_IFU) ? LSU_AR : IFU_AR;
        end else if (i_ifu_arvalid) begin
          state_d = IFU_AR;
        end else if (i_lsu_arvalid) begin
          state_d = LSU_AR;
        end
      end

      IFU_AR: begin
        o_m_arvalid   = i_ifu_arvalid;
        o_m_araddr    = i_ifu_araddr;
        o_m_arid      = ID_IFU;
        o_m_arlen     = i_ifu_arlen;
        o_m_arsize    = i_ifu_arsize;
        o_m_arburst   = i_ifu_arburst;
        o_ifu_arready = i_m_arready;
        if (i_ifu_arvalid && i_m_arready) begin
          ar_hs_c      = 1'b1;
          last_grant_d = GRANT_IFU;
          state_d      = IFU_R;
        end
      end

      IFU_R: begin
        o_ifu_rvalid = i_m_rvalid;
        o_ifu_rdata  = i_m_rdata;
        o_ifu_rresp  = i_m_rresp;
        o_ifu_rlast  = i_m_rlast;
        o_m_rready   = i_ifu_rready;
        if (i_m_rvalid && i_ifu_rready) begin
          r_hs_c = 1'b1;
          if (i_m_rlast) state_d = IDLE;
        end
      end

      LSU_AR: begin
        o_m_arvalid   = i_lsu_arvalid;
        o_m_araddr    = i_lsu_araddr;
        o_m_arid      = ID_LSU;
        o_m_arlen     = i_lsu_arlen;
        o_m_arsize    = i_lsu_arsize;
        o_m_arburst   = i_lsu_arburst;
        o_lsu_arready = i_m_arready;
        if (i_lsu_arvalid && i_m_arready) begin
          ar_hs_c      = 1'b1;
          last_grant_d = GRANT_LSU;
          state_d      = LSU_R;
        end
      end

      LSU_R: begin
        o_lsu_rvalid = i_m_rvalid;
        o_lsu_rdata  = i_m_rdata;
        o_lsu_rresp  = i_m_rresp;
        o_lsu_rlast  = i_m_rlast;
        o_m_rready   = i_lsu_rready;
        if (i_m_rvalid && i_lsu_rready) begin
          r_hs_c = 1'b1;
          if (i_m_rlast) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  axi_rd_beat_chk u_beat_chk (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .ar_load        (ar_hs_c),
    .arlen          (o_m_arlen),
    .r_beat         (r_hs_c),
    .rlast          (i_m_rlast),
    .o_protocol_err (o_protocol_err)
  );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: scripted IFU/LSU/slave traffic, a
// transaction-level reference model compared every cycle, plus literal pins.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [ADDR_W-1:0]  ifu_araddr = '0, lsu_araddr = '0;
  logic [LEN_W-1:0]   ifu_arlen = '0, lsu_arlen = '0;
  logic [SIZE_W-1:0]  ifu_arsize = 3'd2, lsu_arsize = 3'd2;
  logic [BURST_W-1:0] ifu_arburst = 2'b01, lsu_arburst = 2'b01;
  logic ifu_arvalid = 1'b0, lsu_arvalid = 1'b0;
  logic ifu_rready = 1'b1, lsu_rready = 1'b1;
  logic ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, ifu_rlast, lsu_rlast;
  logic [DATA_W-1:0] ifu_rdata, lsu_rdata;
  logic [RESP_W-1:0] ifu_rresp, lsu_rresp;

  logic [ADDR_W-1:0]  m_araddr;
  logic [ID_W-1:0]    m_arid;
  logic [LEN_W-1:0]   m_arlen;
  logic [SIZE_W-1:0]  m_arsize;
  logic [BURST_W-1:0] m_arburst;
  logic m_arvalid, m_rready, protocol_err;
  logic m_arready = 1'b1;
  logic [DATA_W-1:0] m_rdata = '0;
  logic [RESP_W-1:0] m_rresp = '0;
  logic [ID_W-1:0]   m_rid = '0;
  logic m_rlast = 1'b0, m_rvalid = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_ifu_araddr(ifu_araddr), .i_ifu_arlen(ifu_arlen), .i_ifu_arsize(ifu_arsize),
    .i_ifu_arburst(ifu_arburst), .i_ifu_arvalid(ifu_arvalid), .o_ifu_arready(ifu_arready),
    .o_ifu_rdata(ifu_rdata), .o_ifu_rresp(ifu_rresp), .o_ifu_rlast(ifu_rlast),
    .o_ifu_rvalid(ifu_rvalid), .i_ifu_rready(ifu_rready),
    .i_lsu_araddr(lsu_araddr), .i_lsu_arlen(lsu_arlen), .i_lsu_arsize(lsu_arsize),
    .i_lsu_arburst(lsu_arburst), .i_lsu_arvalid(lsu_arvalid), .o_lsu_arready(lsu_arready),
    .o_lsu_rdata(lsu_rdata), .o_lsu_rresp(lsu_rresp), .o_lsu_rlast(lsu_rlast),
    .o_lsu_rvalid(lsu_rvalid), .i_lsu_rready(lsu_rready),
    .o_m_araddr(m_araddr), .o_m_arid(m_arid), .o_m_arlen(m_arlen), .o_m_arsize(m_arsize),
    .o_m_arburst(m_arburst), .o_m_arvalid(m_arvalid), .i_m_arready(m_arready),
    .i_m_rdata(m_rdata), .i_m_rresp(m_rresp), .i_m_rid(m_rid), .i_m_rlast(m_rlast),
    .i_m_rvalid(m_rvalid), .o_m_rready(m_rready),
    .o_protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: who owns the bus (0 none, 1 IFU, 2 LSU), whether its
  // address was accepted, beats seen so far and beats the burst should have.
  int   mo = 0;
  logic mg = 1'b0;
  int   m_prev = 1;
  int   m_seen = 0;
  int   m_total = 0;
  logic merr = 1'b0;

  logic              cur_arv, cur_rrdy;
  logic [LEN_W-1:0]  cur_len;
  assign cur_arv  = (mo == 1) ? ifu_arvalid : lsu_arvalid;
  assign cur_rrdy = (mo == 1) ? ifu_rready  : lsu_rready;
  assign cur_len  = (mo == 1) ? ifu_arlen   : lsu_arlen;

  always @(posedge clk) begin
    if (rst) begin
      mo <= 0; mg <= 1'b0; m_prev <= 1; m_seen <= 0; m_total <= 0; merr <= 1'b0;
    end else if (mo == 0) begin
      if (ifu_arvalid && lsu_arvalid) mo <= (m_prev == 1) ? 2 : 1;
      else if (ifu_arvalid)           mo <= 1;
      else if (lsu_arvalid)           mo <= 2;
    end else if (!mg) begin
      if (cur_arv && m_arready) begin
        mg <= 1'b1; m_prev <= mo; m_seen <= 0; m_total <= int'(cur_len) + 1;
      end
    end else if (m_rvalid && cur_rrdy) begin
      if (m_rlast != (m_seen + 1 == m_total)) merr <= 1'b1;
      m_seen <= m_seen + 1;
      if (m_rlast) begin mo <= 0; mg <= 1'b0; end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_arv, e_irdy, e_lrdy, e_irv, e_lrv, e_mrr;
      e_arv = 1'b0; e_irdy = 1'b0; e_lrdy = 1'b0; e_irv = 1'b0; e_lrv = 1'b0; e_mrr = 1'b0;
      if (mo != 0 && !mg) begin
        e_arv = cur_arv;
        if (mo == 1) e_irdy = m_arready; else e_lrdy = m_arready;
      end else if (mo != 0) begin
        e_mrr = cur_rrdy;
        if (mo == 1) e_irv = m_rvalid; else e_lrv = m_rvalid;
      end
      chk("m_arvalid", 64'(m_arvalid), 64'(e_arv));
      chk("ifu_arready", 64'(ifu_arready), 64'(e_irdy));
      chk("lsu_arready", 64'(lsu_arready), 64'(e_lrdy));
      chk("m_rready", 64'(m_rready), 64'(e_mrr));
      chk("ifu_rvalid", 64'(ifu_rvalid), 64'(e_irv));
      chk("lsu_rvalid", 64'(lsu_rvalid), 64'(e_lrv));
      chk("protocol_err", 64'(protocol_err), 64'(merr));
      if (e_arv) begin
        chk("m_arid", 64'(m_arid), (mo == 1) ? 64'(ID_IFU) : 64'(ID_LSU));
        chk("m_araddr", 64'(m_araddr), (mo == 1) ? 64'(ifu_araddr) : 64'(lsu_araddr));
        chk("m_arlen", 64'(m_arlen), 64'(cur_len));
        chk("m_arsize", 64'(m_arsize), (mo == 1) ? 64'(ifu_arsize) : 64'(lsu_arsize));
        chk("m_arburst", 64'(m_arburst), (mo == 1) ? 64'(ifu_arburst) : 64'(lsu_arburst));
      end
      if (e_irv) begin
        chk("ifu_rdata", 64'(ifu_rdata), 64'(m_rdata));
        chk("ifu_rresp", 64'(ifu_rresp), 64'(m_rresp));
        chk("ifu_rlast", 64'(ifu_rlast), 64'(m_rlast));
      end
      if (e_lrv) begin
        chk("lsu_rdata", 64'(lsu_rdata), 64'(m_rdata));
        chk("lsu_rresp", 64'(lsu_rresp), 64'(m_rresp));
        chk("lsu_rlast", 64'(lsu_rlast), 64'(m_rlast));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic [RESP_W-1:0] r, input logic l);
    m_rvalid = 1'b1; m_rdata = d; m_rresp = r; m_rlast = l;
  endtask

  task automatic no_beat();
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = OKAY;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b1;
    step; chk_en = 1'b1;
    step;
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_protocol_err", 64'(protocol_err), 64'd0);

    // IFU alone, two-beat burst
    rst = 1'b0;
    ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd1; ifu_arvalid = 1'b1;
    step; settle;
    chk("t1_arvalid", 64'(m_arvalid), 64'd1);
    chk("t1_arid", 64'(m_arid), 64'd0);
    chk("t1_araddr", 64'(m_araddr), 64'h3000_0000);
    step;
    ifu_arvalid = 1'b0; beat(32'hAAAA_0001, OKAY, 1'b0); settle;
    chk("t1_beat0", 64'(ifu_rdata), 64'hAAAA_0001);
    chk("t1_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
    step;
    beat(32'hAAAA_0002, OKAY, 1'b1); settle;
    chk("t1_beat1", 64'(ifu_rdata), 64'hAAAA_0002);
    chk("t1_rlast", 64'(ifu_rlast), 64'd1);
    step;
    beat(32'hDEAD_BEEF, OKAY, 1'b0); settle;
    chk("t1_idle_rready", 64'(m_rready), 64'd0);
    chk("t1_idle_rvalid", 64'(ifu_rvalid), 64'd0);
    no_beat();

    // Simultaneous requests after reset: LSU first, IFU after one IDLE cycle
    rst = 1'b1; step; rst = 1'b0;
    ifu_araddr = 32'h3000_0100; ifu_arlen = 8'd0; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h4000_0000; lsu_arlen = 8'd0; lsu_arvalid = 1'b1;
    step; settle;
    chk("t2_arid_lsu", 64'(m_arid), 64'd1);
    chk("t2_araddr_lsu", 64'(m_araddr), 64'h4000_0000);
    chk("t2_ifu_arready", 64'(ifu_arready), 64'd0);
    step;
    lsu_arvalid = 1'b0; beat(32'hBBBB_0001, OKAY, 1'b1); settle;
    chk("t2_lsu_rdata", 64'(lsu_rdata), 64'hBBBB_0001);
    chk("t2_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
    step;
    no_beat(); settle;
    chk("t2_idle_arvalid", 64'(m_arvalid), 64'd0);
    step; settle;
    chk("t2_arid_ifu", 64'(m_arid), 64'd0);
    chk("t2_araddr_ifu", 64'(m_araddr), 64'h3000_0100);
    step;
    ifu_arvalid = 1'b0; beat(32'hCCCC_0001, OKAY, 1'b1); settle;
    chk("t2_ifu_rdata", 64'(ifu_rdata), 64'hCCCC_0001);
    step;
    no_beat();

    // LSU single beat with AR and R backpressure
    lsu_araddr = 32'h4000_0010; lsu_arlen = 8'd0; lsu_arvalid = 1'b1; m_arready = 1'b0;
    step; settle;
    chk("t3_lsu_arready_lo", 64'(lsu_arready), 64'd0);
    step;
    m_arready = 1'b1; settle;
    chk("t3_lsu_arready_hi", 64'(lsu_arready), 64'd1);
    step;
    lsu_arvalid = 1'b0; lsu_rready = 1'b0; beat(32'h5555_1234, OKAY, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("t3_rready_held", 64'(m_rready), 64'd0);
      step;
    end
    lsu_rready = 1'b1; settle;
    chk("t3_rready_up", 64'(m_rready), 64'd1);
    chk("t3_rdata", 64'(lsu_rdata), 64'h5555_1234);
    step;
    no_beat();

    // SLVERR on beat 0 is forwarded and the burst completes
    ifu_araddr = 32'h3000_0200; ifu_arlen = 8'd1; ifu_arvalid = 1'b1;
    step; step;
    ifu_arvalid = 1'b0; beat(32'hDDDD_0001, SLVERR, 1'b0); settle;
    chk("t4_rresp_err", 64'(ifu_rresp), 64'(SLVERR));
    step;
    beat(32'hDDDD_0002, OKAY, 1'b1); settle;
    chk("t4_rresp_ok", 64'(ifu_rresp), 64'(OKAY));
    step;
    no_beat(); settle;
    chk("t4_no_err", 64'(protocol_err), 64'd0);

    // Early rlast sets the sticky error
    ifu_araddr = 32'h3000_0300; ifu_arlen = 8'd1; ifu_arvalid = 1'b1;
    step; step;
    ifu_arvalid = 1'b0; beat(32'hEEEE_0001, OKAY, 1'b1);
    step;
    no_beat(); settle;
    chk("t5_err_set", 64'(protocol_err), 64'd1);
    lsu_araddr = 32'h4000_0020; lsu_arlen = 8'd0; lsu_arvalid = 1'b1;
    step; step;
    lsu_arvalid = 1'b0; beat(32'hEEEE_0002, OKAY, 1'b1);
    step;
    no_beat(); settle;
    chk("t5_err_sticky", 64'(protocol_err), 64'd1);

    // Reset in the middle of an IFU burst
    ifu_araddr = 32'h3000_0400; ifu_arlen = 8'd3; ifu_arvalid = 1'b1;
    step; step;
    ifu_arvalid = 1'b0; beat(32'hF000_0000, OKAY, 1'b0);
    step;
    beat(32'hF000_0001, OKAY, 1'b0); settle;
    chk("t6_in_burst", 64'(ifu_rvalid), 64'd1);
    rst = 1'b1;
    step;
    chk("t6_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
    chk("t6_m_rready", 64'(m_rready), 64'd0);
    chk("t6_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("t6_err_clr", 64'(protocol_err), 64'd0);
    rst = 1'b0; no_beat();
    step; step;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
